// File: rtl/fft16_pkg.sv
// Shared constants, read-FSM state type and bin-order helper for the 16-point FFT output path.
package fft16_pkg;
  localparam int FFT_DATA_W = 16;
  localparam int FFT_PTS    = 16;

  typedef enum logic {S_IDLE, S_STREAM} rd_state_e;

  // Base-4 digit reversal: 4*(c mod 4) + (c div 4) is a swap of the two radix-4 digits.
  function automatic logic [3:0] digitrev(input logic [3:0] c);
    return {c[1:0], c[3:2]};
  endfunction
endpackage

// File: rtl/fft16_frame_bank.sv
// One frame buffer: 16 complex samples captured in parallel, read back one bin at a time.
module fft16_frame_bank
  import fft16_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [FFT_PTS-1:0][DATA_W-1:0]  wr_re,
  input  logic [FFT_PTS-1:0][DATA_W-1:0]  wr_im,
  input  logic [3:0]                      rd_idx,
  output logic [DATA_W-1:0]               rd_re,
  output logic [DATA_W-1:0]               rd_im
);
  logic [FFT_PTS-1:0][DATA_W-1:0] mem_re, mem_im;

  // Contents are qualified by the full flags in the parent, so no reset is needed here.
  always_ff @(posedge clk)
    if (we) begin
      mem_re <= wr_re;
      mem_im <= wr_im;
    end

  assign rd_re = mem_re[rd_idx];
  assign rd_im = mem_im[rd_idx];
endmodule

// File: rtl/fft16_output_serializer.sv
// Ping-pong buffer turning a parallel 16-bin FFT frame into a valid/ready bin stream.
// Define FFT16_OUT_DIGITREV_EN to emit bins in base-4 digit-reversed bank order.
module fft16_output_serializer
  import fft16_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_PTS  = FFT_PTS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_re_0,  in_re_1,  in_re_2,  in_re_3,
  input  logic [DATA_W-1:0] in_re_4,  in_re_5,  in_re_6,  in_re_7,
  input  logic [DATA_W-1:0] in_re_8,  in_re_9,  in_re_10, in_re_11,
  input  logic [DATA_W-1:0] in_re_12, in_re_13, in_re_14, in_re_15,
  input  logic [DATA_W-1:0] in_im_0,  in_im_1,  in_im_2,  in_im_3,
  input  logic [DATA_W-1:0] in_im_4,  in_im_5,  in_im_6,  in_im_7,
  input  logic [DATA_W-1:0] in_im_8,  in_im_9,  in_im_10, in_im_11,
  input  logic [DATA_W-1:0] in_im_12, in_im_13, in_im_14, in_im_15,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [3:0]        out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);
  if (N_PTS != 16) begin : g_bad_npts
    $error("fft16_output_serializer: N_PTS must be 16");
  end

  logic [N_PTS-1:0][DATA_W-1:0] wr_re, wr_im;
  assign wr_re = {in_re_15, in_re_14, in_re_13, in_re_12, in_re_11, in_re_10, in_re_9, in_re_8,
                  in_re_7,  in_re_6,  in_re_5,  in_re_4,  in_re_3,  in_re_2,  in_re_1, in_re_0};
  assign wr_im = {in_im_15, in_im_14, in_im_13, in_im_12, in_im_11, in_im_10, in_im_9, in_im_8,
                  in_im_7,  in_im_6,  in_im_5,  in_im_4,  in_im_3,  in_im_2,  in_im_1, in_im_0};

  logic [1:0] full, full_nxt;
  logic       wr_bank, rd_bank;
  logic [3:0] cnt, rd_idx;
  logic       accept, hs, release_bank;
  rd_state_e  state, state_nxt;

  assign in_ready     = ~full[wr_bank];
  assign accept       = in_valid & in_ready;
  assign hs           = out_valid & out_ready;
  assign release_bank = hs & (cnt == 4'd15);

  // Capture and release always hit different banks: capture needs an empty bank, release a full one.
  always_comb begin
    full_nxt = full;
    if (accept)       full_nxt[wr_bank] = 1'b1;
    if (release_bank) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      full     <= full_nxt;
      wr_bank  <= wr_bank ^ accept;
      rd_bank  <= rd_bank ^ release_bank;
      cnt      <= hs ? cnt + 4'd1 : cnt;
      overflow <= in_valid & ~in_ready;
    end

  // Looking at next-cycle full flags gives 1-cycle capture latency and no gap between frames.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (full_nxt[rd_bank]) state_nxt = S_STREAM;
      S_STREAM: if (release_bank && !full_nxt[~rd_bank]) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == S_STREAM);
    out_last  = out_valid & (cnt == 4'd15);
    out_index = cnt;
  end

`ifdef FFT16_OUT_DIGITREV_EN
  assign rd_idx = digitrev(cnt);
`else
  assign rd_idx = cnt;
`endif

  logic [DATA_W-1:0] a_re, a_im, b_re, b_im;

  fft16_frame_bank #(.DATA_W(DATA_W)) u_bank_a (
    .clk(clk), .we(accept & ~wr_bank), .wr_re(wr_re), .wr_im(wr_im),
    .rd_idx(rd_idx), .rd_re(a_re), .rd_im(a_im)
  );

  fft16_frame_bank #(.DATA_W(DATA_W)) u_bank_b (
    .clk(clk), .we(accept & wr_bank), .wr_re(wr_re), .wr_im(wr_im),
    .rd_idx(rd_idx), .rd_re(b_re), .rd_im(b_im)
  );

  assign out_re = rd_bank ? b_re : a_re;
  assign out_im = rd_bank ? b_im : a_im;
endmodule

// File: tb/tb_fft16_output_serializer.sv
// Directed + random bench: expected bins are queued on capture and compared as the stream emits them.
module tb_fft16_output_serializer;
  logic        clk, rst, in_valid, out_ready;
  logic [15:0] in_re [16];
  logic [15:0] in_im [16];
  logic        in_ready, out_last, out_valid, overflow;
  logic [15:0] out_re, out_im;
  logic [3:0]  out_index;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  ovf_exp = 1'b0;

  fft16_output_serializer dut (
    .clk(clk), .rst(rst),
    .in_re_0(in_re[0]),   .in_re_1(in_re[1]),   .in_re_2(in_re[2]),   .in_re_3(in_re[3]),
    .in_re_4(in_re[4]),   .in_re_5(in_re[5]),   .in_re_6(in_re[6]),   .in_re_7(in_re[7]),
    .in_re_8(in_re[8]),   .in_re_9(in_re[9]),   .in_re_10(in_re[10]), .in_re_11(in_re[11]),
    .in_re_12(in_re[12]), .in_re_13(in_re[13]), .in_re_14(in_re[14]), .in_re_15(in_re[15]),
    .in_im_0(in_im[0]),   .in_im_1(in_im[1]),   .in_im_2(in_im[2]),   .in_im_3(in_im[3]),
    .in_im_4(in_im[4]),   .in_im_5(in_im[5]),   .in_im_6(in_im[6]),   .in_im_7(in_im[7]),
    .in_im_8(in_im[8]),   .in_im_9(in_im[9]),   .in_im_10(in_im[10]), .in_im_11(in_im[11]),
    .in_im_12(in_im[12]), .in_im_13(in_im[13]), .in_im_14(in_im[14]), .in_im_15(in_im[15]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_re(out_re), .out_im(out_im), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input int base);
    for (int i = 0; i < 16; i++) begin
      in_re[i] = 16'(base + i);
      in_im[i] = 16'(-(base + i));
    end
  endtask

  // Queue the 16 bins of the frame on the inputs, in the order the stream should emit them.
  task automatic push_frame();
    beat_t e;
    int    pos;
    for (int c = 0; c < 16; c++) begin
`ifdef FFT16_OUT_DIGITREV_EN
      pos = 4 * (c % 4) + c / 4;
`else
      pos = c;
`endif
      e.re   = in_re[pos];
      e.im   = in_im[pos];
      e.idx  = 4'(c);
      e.last = (c == 15);
      sb.push_back(e);
    end
  endtask

  // One clock: check outputs at the falling edge, update the model, then step past the rising edge.
  task automatic tick();
    int   held;
    logic rdy_exp, acc, hs;
    @(negedge clk);
    held    = (sb.size() + 15) / 16;
    rdy_exp = (held < 2);
    chk("in_ready", in_ready, rdy_exp);
    chk("out_valid", out_valid, sb.size() > 0);
    chk("overflow", overflow, ovf_exp);
    if (sb.size() > 0) begin
      chk("out_re", out_re, sb[0].re);
      chk("out_im", out_im, sb[0].im);
      chk("out_index", out_index, sb[0].idx);
      chk("out_last", out_last, sb[0].last);
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
    ovf_exp = in_valid && !rdy_exp;
    acc     = in_valid && rdy_exp;
    hs      = (sb.size() > 0) && out_ready;
    if (hs)  void'(sb.pop_front());
    if (acc) push_frame();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_index", out_index, 4'd0);
    chk("rst_overflow", overflow, 1'b0);
    sb.delete();
    ovf_exp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_frame(0);
    do_reset();

    // single frame i / -i
    set_frame(0); in_valid = 1'b1; tick();
    in_valid = 1'b0; repeat (20) tick();

    // back-to-back frames, third one dropped while both banks are full
    set_frame(16); in_valid = 1'b1; tick();
    set_frame(32); tick();
    set_frame(48); tick();
    in_valid = 1'b0; repeat (40) tick();

    // stall on beat 3
    set_frame(64); in_valid = 1'b1; tick();
    in_valid = 1'b0; repeat (3) tick();
    out_ready = 1'b0; repeat (2) tick();
    out_ready = 1'b1; repeat (16) tick();

    // new frame on the last-beat handshake, other bank free
    set_frame(80); in_valid = 1'b1; tick();
    in_valid = 1'b0; repeat (15) tick();
    set_frame(96); in_valid = 1'b1; tick();
    in_valid = 1'b0; repeat (20) tick();

    // new frame on the last-beat handshake, target bank still full -> dropped
    set_frame(112); in_valid = 1'b1; tick();
    set_frame(128); tick();
    in_valid = 1'b0; repeat (14) tick();
    set_frame(200); in_valid = 1'b1; tick();
    in_valid = 1'b0; repeat (40) tick();

    // reset while streaming beat 7
    set_frame(144); in_valid = 1'b1; tick();
    in_valid = 1'b0; repeat (7) tick();
    do_reset();
    set_frame(160); in_valid = 1'b1; tick();
    in_valid = 1'b0; repeat (20) tick();

    // sustained one frame every 16 clocks
    base = 300;
    repeat (4) begin
      set_frame(base); in_valid = 1'b1; tick();
      in_valid = 1'b0; repeat (15) tick();
      base += 16;
    end
    repeat (20) tick();

    // random traffic with backpressure
    repeat (300) begin
      in_valid = ($urandom_range(0, 3) == 0);
      if (in_valid) set_frame(int'($urandom_range(0, 60000)));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
